dcm_lock_supervisor: RTL and testbench
======================================

# dcm_lock_supervisor

Parametrised lock supervisor for up to NUM_CHANNELS DCM_SP instances, such as the camera and system clock DCMs. Per channel, it drives the DCM RST pin, watches LOCKED, and retries on a lock timeout. It requires lock to stay stable before it declares the clock ready. It also detects lock loss in service and latches a fault after repeated failed attempts. It sits beside the DCMs on the free-running board input clock. Its per-channel ready flags and its all_ready flag gate downstream logic out of reset.

## Interface
- NUM_CHANNELS, 2: number of supervised DCMs (≥1)
- PRESCALE, 2: input_clk cycles per timing tick (≥1; 1 = tick every cycle)
- RESET_PULSE, 10: ticks dcm_reset is held high per attempt (≥1)
- LOCK_TIMEOUT, 50000: ticks allowed for LOCKED to rise per attempt (≥1)
- SETTLE_CYCLES, 1024: ticks LOCKED must stay high before ready (≥1)
- MAX_RETRIES, 4: failed attempts in a row before fault (≥1)

Ports:
- input_clk  in  1  the only clock; free-running board clock
- reset  in  1  synchronous, active-high
- channel_enable  in  NUM_CHANNELS  per-channel enable; level-sensitive
- dcm_locked  in  NUM_CHANNELS  DCM LOCKED outputs; asynchronous
- dcm_reset  out  NUM_CHANNELS  to DCM RST; registered
- clock_ready  out  NUM_CHANNELS  channel in RUN; registered
- all_ready  out  1  every enabled channel ready and at least one enabled; registered
- lock_lost  out  NUM_CHANNELS  one-cycle pulse when LOCKED drops in RUN
- fault  out  NUM_CHANNELS  channel in FAULT; registered

## Operation
- Each dcm_locked bit passes through a 2-flop synchronizer. All decisions use the synchronized value lock_s.
- A single shared prescaler counter generates tick, which is high one cycle in every PRESCALE cycles.
- Each channel has a per-channel FSM, a tick counter and a retry counter.
- Counter width is $clog2(max(RESET_PULSE, LOCK_TIMEOUT, SETTLE_CYCLES)+1). Retry width is $clog2(MAX_RETRIES+1). Counters never wrap.
- The FSM states are:
  - IDLE: dcm_reset=1, outputs 0. If channel_enable=1, go to HOLD_RESET on the next edge (not tick-gated), with counter=0 and retries=0.
  - HOLD_RESET: dcm_reset=1. The counter increments on each tick. On a tick with counter==RESET_PULSE-1, go to WAIT_LOCK with counter=0.
  - WAIT_LOCK: dcm_reset=0. On a tick:
    - If lock_s=1, go to SETTLE with counter=0.
    - Otherwise, if counter==LOCK_TIMEOUT-1, this is a failed attempt.
    - Otherwise, counter++.
  - SETTLE: dcm_reset=0. On a tick:
    - If lock_s=0, this is a failed attempt.
    - Otherwise, if counter==SETTLE_CYCLES-1, go to RUN with retries=0.
    - Otherwise, counter++.
  - RUN: clock_ready=1. If lock_s=0 on a tick, pulse lock_lost for one cycle and go to HOLD_RESET with counter=0. A lock loss is not counted as a retry.
  - FAULT: dcm_reset=1, fault=1, clock_ready=0. It is left only via reset or channel_enable=0.
- A failed attempt does the following: if retries==MAX_RETRIES-1, go to FAULT; otherwise retries++ and go to HOLD_RESET with counter=0.
- channel_enable=0 in any state forces the channel to IDLE on the next edge. This takes priority over all other transitions. The deassertion is not tick-gated.
- clock_ready, fault and dcm_reset are registered from the next state, so they change on the same edge as the state.
- all_ready is registered from the current clock_ready and channel_enable values, so it lags clock_ready by one cycle. Disabled channels are ignored. all_ready is 0 when no channel is enabled.
- Channels are fully independent and share only the prescaler.

## Timing
- During reset and on the first edge after it: dcm_reset=all 1s; clock_ready, all_ready, lock_lost and fault are 0. All FSMs are in IDLE, all counters are 0 and the synchronizers are 0.
- dcm_reset is continuously high from reset through the end of HOLD_RESET, with no glitch low between IDLE and HOLD_RESET.
- The figures below are for PRESCALE=1, with edge 1 being the first edge with reset low and the enable already high:
  - dcm_reset falls at edge 1+RESET_PULSE.
  - If dcm_locked rises before edge k, clock_ready rises at edge k+2+SETTLE_CYCLES at the earliest. The extra 2 edges are the synchronizer.
  - all_ready rises one edge after the last enabled channel's clock_ready.
  - Each failed timeout attempt costs RESET_PULSE+LOCK_TIMEOUT edges. fault rises at edge 1+MAX_RETRIES·(RESET_PULSE+LOCK_TIMEOUT) if lock never arrives.
- If dcm_locked falls in RUN, lock_lost pulses and clock_ready falls 3 edges later (synchronizer plus the FSM edge), together with dcm_reset rising.
- If reset is asserted mid-operation, the next edge restores all reset values, including dcm_reset=1.

## Test plan
- PRESCALE=1, RESET_PULSE=4, LOCK_TIMEOUT=20, SETTLE_CYCLES=8, MAX_RETRIES=3, one channel enabled. Raise dcm_locked 3 cycles after dcm_reset falls -> dcm_reset low from edge 5, clock_ready high at the predicted edge, all_ready one edge later.
- Same parameters, dcm_locked held at 0 -> dcm_reset pulses of 4 edges separated by 20-edge waits, 3 times. fault rises at edge 73 and dcm_reset stays high afterwards. Dropping channel_enable then restoring it restarts the sequence.
- In RUN, drop dcm_locked for 2 cycles -> single-cycle lock_lost pulse, clock_ready=0, new 4-tick dcm_reset pulse, no increment of retries, relock to RUN.
- In SETTLE, glitch dcm_locked low for one tick -> counted as a failed attempt, HOLD_RESET entered, clock_ready never asserted during the glitch.
- Two channels, channel 1 disabled -> all_ready follows channel 0 alone and dcm_reset[1] stays 1. Disabling both channels -> all_ready=0.
- PRESCALE=3, then assert reset mid-WAIT_LOCK -> all durations scale by 3; after reset, all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/dcm_lock_supervisor.sv
// Lock supervisor for a bank of DCM_SP instances: sequences RST, waits for LOCKED,
// demands a stable settle window, retries on timeout and latches a fault.
module dcm_lock_supervisor #(
  parameter int NUM_CHANNELS  = 2,
  parameter int PRESCALE      = 2,
  parameter int RESET_PULSE   = 10,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int SETTLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 4
) (
  input  logic                    input_clk,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] channel_enable,
  input  logic [NUM_CHANNELS-1:0] dcm_locked,
  output logic [NUM_CHANNELS-1:0] dcm_reset,
  output logic [NUM_CHANNELS-1:0] clock_ready,
  output logic                    all_ready,
  output logic [NUM_CHANNELS-1:0] lock_lost,
  output logic [NUM_CHANNELS-1:0] fault
);

  localparam int MAX_RT  = (RESET_PULSE > LOCK_TIMEOUT) ? RESET_PULSE : LOCK_TIMEOUT;
  localparam int MAX_ALL = (MAX_RT > SETTLE_CYCLES) ? MAX_RT : SETTLE_CYCLES;
  localparam int CW      = $clog2(MAX_ALL + 1);
  localparam int RW      = $clog2(MAX_RETRIES + 1);
  localparam int PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [CW-1:0] RESET_LAST   = CW'(RESET_PULSE - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LAST   = RW'(MAX_RETRIES - 1);
  localparam logic [PW-1:0] PRE_LAST     = PW'(PRESCALE - 1);

  typedef enum logic [2:0] {
    IDLE,
    HOLD_RESET,
    WAIT_LOCK,
    SETTLE,
    RUN,
    FAULT
  } state_t;

  logic [PW-1:0]           pre_cnt;
  logic                    tick;
  logic [NUM_CHANNELS-1:0] sync_q;
  logic [NUM_CHANNELS-1:0] lock_s;

  assign tick = (pre_cnt == PRE_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge input_clk) begin
    if (reset) begin
      pre_cnt <= '0;
      sync_q  <= '0;
      lock_s  <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      sync_q  <= dcm_locked;
      lock_s  <= sync_q;
    end
  end

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [RW-1:0] rty, rty_n;
    logic          lost_n;
    logic          fail;
    logic          rst_q, ready_q, fault_q, lost_q;

    // NOTE: every always_comb output is defaulted first so no path infers a latch.
    always_comb begin
      state_n = state;
      cnt_n   = cnt;
      rty_n   = rty;
      lost_n  = 1'b0;
      fail    = 1'b0;
      if (!channel_enable[i]) begin
        state_n = IDLE;
        cnt_n   = '0;
        rty_n   = '0;
      end else begin
        case (state)
          IDLE: begin
            state_n = HOLD_RESET;
            cnt_n   = '0;
            rty_n   = '0;
          end
          HOLD_RESET: if (tick) begin
            if (cnt == RESET_LAST) begin
              state_n = WAIT_LOCK;
              cnt_n   = '0;
            end else cnt_n = cnt + 1'b1;
          end
          WAIT_LOCK: if (tick) begin
            if (lock_s[i]) begin
              state_n = SETTLE;
              cnt_n   = '0;
            end else if (cnt == TIMEOUT_LAST) fail = 1'b1;
            else cnt_n = cnt + 1'b1;
          end
          SETTLE: if (tick) begin
            if (!lock_s[i]) fail = 1'b1;
            else if (cnt == SETTLE_LAST) begin
              state_n = RUN;
              rty_n   = '0;
            end else cnt_n = cnt + 1'b1;
          end
          RUN: if (tick && !lock_s[i]) begin
            // Lock loss in service restarts the DCM without spending a retry.
            lost_n  = 1'b1;
            state_n = HOLD_RESET;
            cnt_n   = '0;
          end
          FAULT:   state_n = FAULT;
          default: state_n = IDLE;
        endcase
        if (fail) begin
          if (rty == RETRY_LAST) state_n = FAULT;
          else begin
            rty_n   = rty + 1'b1;
            state_n = HOLD_RESET;
            cnt_n   = '0;
          end
        end
      end
    end

    // Outputs register the next state so they move on the same edge as the FSM.
    always_ff @(posedge input_clk) begin
      if (reset) begin
        state   <= IDLE;
        cnt     <= '0;
        rty     <= '0;
        rst_q   <= 1'b1;
        ready_q <= 1'b0;
        fault_q <= 1'b0;
        lost_q  <= 1'b0;
      end else begin
        state   <= state_n;
        cnt     <= cnt_n;
        rty     <= rty_n;
        rst_q   <= (state_n == IDLE) || (state_n == HOLD_RESET) || (state_n == FAULT);
        ready_q <= (state_n == RUN);
        fault_q <= (state_n == FAULT);
        lost_q  <= lost_n;
      end
    end

    assign dcm_reset[i]   = rst_q;
    assign clock_ready[i] = ready_q;
    assign fault[i]       = fault_q;
    assign lock_lost[i]   = lost_q;
  end

  always_ff @(posedge input_clk) begin
    if (reset) all_ready <= 1'b0;
    else       all_ready <= (|channel_enable) && (&(clock_ready | ~channel_enable));
  end

endmodule

// File: tb/tb_dcm_lock_supervisor.sv
// Directed bench: dut_a (PRESCALE=1, two channels) and dut_b (PRESCALE=3, one channel)
// with edge-numbered expectations derived by hand from the timing rules.
module tb_dcm_lock_supervisor;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [1:0] channel_enable, dcm_locked;
  logic [1:0] dcm_reset, clock_ready, lock_lost, fault;
  logic       all_ready;

  logic       reset_b;
  logic [0:0] en_b, locked_b, dr_b, cr_b, lost_b, fault_b;
  logic       all_b;

  int passed = 0;
  int total  = 0;
  int cur    = 0;

  dcm_lock_supervisor #(
    .NUM_CHANNELS(2), .PRESCALE(1), .RESET_PULSE(4),
    .LOCK_TIMEOUT(20), .SETTLE_CYCLES(8), .MAX_RETRIES(3)
  ) dut_a (
    .input_clk(clk), .reset(reset), .channel_enable(channel_enable),
    .dcm_locked(dcm_locked), .dcm_reset(dcm_reset), .clock_ready(clock_ready),
    .all_ready(all_ready), .lock_lost(lock_lost), .fault(fault)
  );

  dcm_lock_supervisor #(
    .NUM_CHANNELS(1), .PRESCALE(3), .RESET_PULSE(4),
    .LOCK_TIMEOUT(20), .SETTLE_CYCLES(8), .MAX_RETRIES(3)
  ) dut_b (
    .input_clk(clk), .reset(reset_b), .channel_enable(en_b),
    .dcm_locked(locked_b), .dcm_reset(dr_b), .clock_ready(cr_b),
    .all_ready(all_b), .lock_lost(lost_b), .fault(fault_b)
  );

  // Advance to edge number `target`, then sample 1 time unit after it.
  task automatic at(input int target);
    while (cur < target) begin
      @(posedge clk);
      #1;
      cur++;
    end
  endtask

  // Disable channel 0 long enough to flush the synchronizer, then re-enable;
  // the next edge becomes edge 1.
  task automatic restart();
    channel_enable = 2'b00;
    dcm_locked     = 2'b00;
    cur = 0;
    at(3);
    total++; if (dcm_reset !== 2'b11) $display("FAIL restart_dcm_reset: got %b expected 11", dcm_reset); else passed++;
    total++; if (fault !== 2'b00) $display("FAIL restart_fault: got %b expected 00", fault); else passed++;
    total++; if (clock_ready !== 2'b00) $display("FAIL restart_clock_ready: got %b expected 00", clock_ready); else passed++;
    channel_enable = 2'b01;
    cur = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    channel_enable = 2'b01;
    dcm_locked = 2'b00;
    cur = 0;
    at(3);
    total++; if (dcm_reset !== 2'b11) $display("FAIL reset_dcm_reset: got %b expected 11", dcm_reset); else passed++;
    total++; if (clock_ready !== 2'b00) $display("FAIL reset_clock_ready: got %b expected 00", clock_ready); else passed++;
    total++; if (all_ready !== 1'b0) $display("FAIL reset_all_ready: got %b expected 0", all_ready); else passed++;
    total++; if (lock_lost !== 2'b00) $display("FAIL reset_lock_lost: got %b expected 00", lock_lost); else passed++;
    total++; if (fault !== 2'b00) $display("FAIL reset_fault: got %b expected 00", fault); else passed++;
  endtask

  task automatic test_lock_acquire();
    reset = 1'b0;
    cur = 0;
    at(1);
    total++; if (dcm_reset !== 2'b11) $display("FAIL acq_e1_dcm_reset: got %b expected 11", dcm_reset); else passed++;
    at(4);
    total++; if (dcm_reset !== 2'b11) $display("FAIL acq_e4_dcm_reset: got %b expected 11", dcm_reset); else passed++;
    at(5);
    total++; if (dcm_reset !== 2'b10) $display("FAIL acq_e5_dcm_reset: got %b expected 10", dcm_reset); else passed++;
    at(7);
    dcm_locked = 2'b01;
    at(17);
    total++; if (clock_ready !== 2'b00) $display("FAIL acq_e17_clock_ready: got %b expected 00", clock_ready); else passed++;
    at(18);
    total++; if (clock_ready !== 2'b01) $display("FAIL acq_e18_clock_ready: got %b expected 01", clock_ready); else passed++;
    total++; if (all_ready !== 1'b0) $display("FAIL acq_e18_all_ready: got %b expected 0", all_ready); else passed++;
    at(19);
    total++; if (all_ready !== 1'b1) $display("FAIL acq_e19_all_ready: got %b expected 1", all_ready); else passed++;
    total++; if (dcm_reset !== 2'b10) $display("FAIL acq_e19_dcm_reset: got %b expected 10", dcm_reset); else passed++;
  endtask

  task automatic test_lock_loss();
    dcm_locked = 2'b00;
    at(21);
    total++; if (clock_ready !== 2'b01) $display("FAIL loss_e21_clock_ready: got %b expected 01", clock_ready); else passed++;
    total++; if (lock_lost !== 2'b00) $display("FAIL loss_e21_lock_lost: got %b expected 00", lock_lost); else passed++;
    dcm_locked = 2'b01;
    at(22);
    total++; if (lock_lost !== 2'b01) $display("FAIL loss_e22_lock_lost: got %b expected 01", lock_lost); else passed++;
    total++; if (clock_ready !== 2'b00) $display("FAIL loss_e22_clock_ready: got %b expected 00", clock_ready); else passed++;
    total++; if (dcm_reset !== 2'b11) $display("FAIL loss_e22_dcm_reset: got %b expected 11", dcm_reset); else passed++;
    total++; if (all_ready !== 1'b1) $display("FAIL loss_e22_all_ready: got %b expected 1", all_ready); else passed++;
    at(23);
    total++; if (lock_lost !== 2'b00) $display("FAIL loss_e23_lock_lost: got %b expected 00", lock_lost); else passed++;
    total++; if (all_ready !== 1'b0) $display("FAIL loss_e23_all_ready: got %b expected 0", all_ready); else passed++;
    at(25);
    total++; if (dcm_reset !== 2'b11) $display("FAIL loss_e25_dcm_reset: got %b expected 11", dcm_reset); else passed++;
    at(26);
    total++; if (dcm_reset !== 2'b10) $display("FAIL loss_e26_dcm_reset: got %b expected 10", dcm_reset); else passed++;
    at(34);
    total++; if (clock_ready !== 2'b00) $display("FAIL loss_e34_clock_ready: got %b expected 00", clock_ready); else passed++;
    at(35);
    total++; if (clock_ready !== 2'b01) $display("FAIL loss_e35_clock_ready: got %b expected 01", clock_ready); else passed++;
  endtask

  // A lost lock followed by no relock must still allow three full attempts.
  task automatic test_loss_no_retry();
    dcm_locked = 2'b00;
    at(37);
    total++; if (clock_ready !== 2'b01) $display("FAIL noretry_e37_clock_ready: got %b expected 01", clock_ready); else passed++;
    at(38);
    total++; if (lock_lost !== 2'b01) $display("FAIL noretry_e38_lock_lost: got %b expected 01", lock_lost); else passed++;
    at(86);
    total++; if (fault !== 2'b00) $display("FAIL noretry_e86_fault: got %b expected 00", fault); else passed++;
    at(109);
    total++; if (fault !== 2'b00) $display("FAIL noretry_e109_fault: got %b expected 00", fault); else passed++;
    at(110);
    total++; if (fault !== 2'b01) $display("FAIL noretry_e110_fault: got %b expected 01", fault); else passed++;
  endtask

  task automatic test_timeout_fault();
    restart();
    at(4);
    total++; if (dcm_reset !== 2'b11) $display("FAIL tmo_e4_dcm_reset: got %b expected 11", dcm_reset); else passed++;
    at(5);
    total++; if (dcm_reset !== 2'b10) $display("FAIL tmo_e5_dcm_reset: got %b expected 10", dcm_reset); else passed++;
    at(24);
    total++; if (dcm_reset !== 2'b10) $display("FAIL tmo_e24_dcm_reset: got %b expected 10", dcm_reset); else passed++;
    at(25);
    total++; if (dcm_reset !== 2'b11) $display("FAIL tmo_e25_dcm_reset: got %b expected 11", dcm_reset); else passed++;
    at(28);
    total++; if (dcm_reset !== 2'b11) $display("FAIL tmo_e28_dcm_reset: got %b expected 11", dcm_reset); else passed++;
    at(29);
    total++; if (dcm_reset !== 2'b10) $display("FAIL tmo_e29_dcm_reset: got %b expected 10", dcm_reset); else passed++;
    at(48);
    total++; if (dcm_reset !== 2'b10) $display("FAIL tmo_e48_dcm_reset: got %b expected 10", dcm_reset); else passed++;
    at(49);
    total++; if (dcm_reset !== 2'b11) $display("FAIL tmo_e49_dcm_reset: got %b expected 11", dcm_reset); else passed++;
    at(53);
    total++; if (dcm_reset !== 2'b10) $display("FAIL tmo_e53_dcm_reset: got %b expected 10", dcm_reset); else passed++;
    at(72);
    total++; if (fault !== 2'b00) $display("FAIL tmo_e72_fault: got %b expected 00", fault); else passed++;
    total++; if (dcm_reset !== 2'b10) $display("FAIL tmo_e72_dcm_reset: got %b expected 10", dcm_reset); else passed++;
    at(73);
    total++; if (fault !== 2'b01) $display("FAIL tmo_e73_fault: got %b expected 01", fault); else passed++;
    total++; if (dcm_reset !== 2'b11) $display("FAIL tmo_e73_dcm_reset: got %b expected 11", dcm_reset); else passed++;
    total++; if (clock_ready !== 2'b00) $display("FAIL tmo_e73_clock_ready: got %b expected 00", clock_ready); else passed++;
    at(83);
    total++; if (fault !== 2'b01) $display("FAIL tmo_e83_fault: got %b expected 01", fault); else passed++;
    total++; if (dcm_reset !== 2'b11) $display("FAIL tmo_e83_dcm_reset: got %b expected 11", dcm_reset); else passed++;
    channel_enable = 2'b00;
    at(84);
    total++; if (fault !== 2'b00) $display("FAIL tmo_disable_fault: got %b expected 00", fault); else passed++;
    total++; if (dcm_reset !== 2'b11) $display("FAIL tmo_disable_dcm_reset: got %b expected 11", dcm_reset); else passed++;
    channel_enable = 2'b01;
    cur = 0;
    at(4);
    total++; if (dcm_reset !== 2'b11) $display("FAIL tmo_restart_e4_dcm_reset: got %b expected 11", dcm_reset); else passed++;
    at(5);
    total++; if (dcm_reset !== 2'b10) $display("FAIL tmo_restart_e5_dcm_reset: got %b expected 10", dcm_reset); else passed++;
  endtask

  task automatic test_settle_glitch();
    restart();
    at(7);
    dcm_locked = 2'b01;
    for (int e = 10; e <= 14; e++) begin
      at(e);
      if (e == 12) dcm_locked = 2'b00;
      if (e == 13) dcm_locked = 2'b01;
      total++; if (clock_ready !== 2'b00) $display("FAIL glitch_e%0d_clock_ready: got %b expected 00", e, clock_ready); else passed++;
    end
    total++; if (dcm_reset !== 2'b10) $display("FAIL glitch_e14_dcm_reset: got %b expected 10", dcm_reset); else passed++;
    at(15);
    total++; if (dcm_reset !== 2'b11) $display("FAIL glitch_e15_dcm_reset: got %b expected 11", dcm_reset); else passed++;
    total++; if (clock_ready !== 2'b00) $display("FAIL glitch_e15_clock_ready: got %b expected 00", clock_ready); else passed++;
    total++; if (lock_lost !== 2'b00) $display("FAIL glitch_e15_lock_lost: got %b expected 00", lock_lost); else passed++;
    at(18);
    total++; if (dcm_reset !== 2'b11) $display("FAIL glitch_e18_dcm_reset: got %b expected 11", dcm_reset); else passed++;
    at(19);
    total++; if (dcm_reset !== 2'b10) $display("FAIL glitch_e19_dcm_reset: got %b expected 10", dcm_reset); else passed++;
    at(27);
    total++; if (clock_ready !== 2'b00) $display("FAIL glitch_e27_clock_ready: got %b expected 00", clock_ready); else passed++;
    at(28);
    total++; if (clock_ready !== 2'b01) $display("FAIL glitch_e28_clock_ready: got %b expected 01", clock_ready); else passed++;
    total++; if (fault !== 2'b00) $display("FAIL glitch_e28_fault: got %b expected 00", fault); else passed++;
  endtask

  task automatic test_channel_mask();
    at(29);
    total++; if (all_ready !== 1'b1) $display("FAIL mask_e29_all_ready: got %b expected 1", all_ready); else passed++;
    total++; if (dcm_reset[1] !== 1'b1) $display("FAIL mask_e29_dcm_reset1: got %b expected 1", dcm_reset[1]); else passed++;
    channel_enable = 2'b11;
    at(30);
    total++; if (all_ready !== 1'b0) $display("FAIL mask_e30_all_ready: got %b expected 0", all_ready); else passed++;
    total++; if (dcm_reset !== 2'b10) $display("FAIL mask_e30_dcm_reset: got %b expected 10", dcm_reset); else passed++;
    total++; if (clock_ready !== 2'b01) $display("FAIL mask_e30_clock_ready: got %b expected 01", clock_ready); else passed++;
    channel_enable = 2'b00;
    at(31);
    total++; if (clock_ready !== 2'b00) $display("FAIL mask_e31_clock_ready: got %b expected 00", clock_ready); else passed++;
    total++; if (dcm_reset !== 2'b11) $display("FAIL mask_e31_dcm_reset: got %b expected 11", dcm_reset); else passed++;
    at(33);
    total++; if (all_ready !== 1'b0) $display("FAIL mask_e33_all_ready: got %b expected 0", all_ready); else passed++;
  endtask

  task automatic test_prescale_reset();
    reset_b = 1'b0;
    cur = 0;
    at(1);
    total++; if (dr_b !== 1'b1) $display("FAIL pre_e1_dcm_reset: got %b expected 1", dr_b); else passed++;
    at(11);
    total++; if (dr_b !== 1'b1) $display("FAIL pre_e11_dcm_reset: got %b expected 1", dr_b); else passed++;
    at(12);
    total++; if (dr_b !== 1'b0) $display("FAIL pre_e12_dcm_reset: got %b expected 0", dr_b); else passed++;
    at(71);
    total++; if (dr_b !== 1'b0) $display("FAIL pre_e71_dcm_reset: got %b expected 0", dr_b); else passed++;
    at(72);
    total++; if (dr_b !== 1'b1) $display("FAIL pre_e72_dcm_reset: got %b expected 1", dr_b); else passed++;
    at(83);
    total++; if (dr_b !== 1'b1) $display("FAIL pre_e83_dcm_reset: got %b expected 1", dr_b); else passed++;
    at(84);
    total++; if (dr_b !== 1'b0) $display("FAIL pre_e84_dcm_reset: got %b expected 0", dr_b); else passed++;
    at(90);
    reset_b = 1'b1;
    at(91);
    total++; if (dr_b !== 1'b1) $display("FAIL pre_rst_dcm_reset: got %b expected 1", dr_b); else passed++;
    total++; if (cr_b !== 1'b0) $display("FAIL pre_rst_clock_ready: got %b expected 0", cr_b); else passed++;
    total++; if (fault_b !== 1'b0) $display("FAIL pre_rst_fault: got %b expected 0", fault_b); else passed++;
    total++; if (lost_b !== 1'b0) $display("FAIL pre_rst_lock_lost: got %b expected 0", lost_b); else passed++;
    total++; if (all_b !== 1'b0) $display("FAIL pre_rst_all_ready: got %b expected 0", all_b); else passed++;
    reset_b = 1'b0;
    cur = 0;
    at(11);
    total++; if (dr_b !== 1'b1) $display("FAIL pre_again_e11_dcm_reset: got %b expected 1", dr_b); else passed++;
    at(12);
    total++; if (dr_b !== 1'b0) $display("FAIL pre_again_e12_dcm_reset: got %b expected 0", dr_b); else passed++;
  endtask

  initial begin
    reset          = 1'b1;
    channel_enable = 2'b01;
    dcm_locked     = 2'b00;
    reset_b        = 1'b1;
    en_b           = 1'b1;
    locked_b       = 1'b0;
    test_reset();
    test_lock_acquire();
    test_lock_loss();
    test_loss_no_retry();
    test_timeout_fault();
    test_settle_glitch();
    test_channel_mask();
    test_prescale_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
